// File: rtl/id_ex_register.sv
// id_ex_register: decode-to-execute pipeline register with write-back bypass,
// load-use bubble insertion and execute-side stall/flush handling.
module id_ex_register #(
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [4:0]        id_dest,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [31:0]       rf_read_data1,
    input  logic [31:0]       rf_read_data2,
    input  logic              wb_reg_write_enable,
    input  logic [4:0]        wb_reg_write_addr,
    input  logic [31:0]       wb_reg_write_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);
    logic              valid_q, valid_d;
    logic [31:0]       rs_data_q, rs_data_d;
    logic [31:0]       rt_data_q, rt_data_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        dest_q, dest_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       pc_q, pc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic [31:0]       rs_res, rt_res;
    logic              hazard;

    always_comb begin
        // The register file returns the old value on read-during-write, so bypass WB here.
        rs_res = (id_rs == 5'd0) ? 32'd0 :
                 (wb_reg_write_enable && wb_reg_write_addr == id_rs) ? wb_reg_write_data : rf_read_data1;
        rt_res = (id_rt == 5'd0) ? 32'd0 :
                 (wb_reg_write_enable && wb_reg_write_addr == id_rt) ? wb_reg_write_data : rf_read_data2;
        hazard = id_valid & valid_q & mem_read_q & (dest_q != 5'd0) &
                 ((id_uses_rs & (dest_q == id_rs)) | (id_uses_rt & (dest_q == id_rt)));
        id_stall = ~flush & (ex_stall | hazard);
        valid_d = valid_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        rs_d = rs_q;
        rt_d = rt_q;
        dest_d = dest_q;
        imm_d = imm_q;
        pc_d = pc_q;
        ctrl_d = ctrl_q;
        reg_write_d = reg_write_q;
        mem_read_d = mem_read_q;
        if (flush) begin
            valid_d = 1'b0;
            rs_data_d = '0;
            rt_data_d = '0;
            rs_d = '0;
            rt_d = '0;
            dest_d = '0;
            imm_d = '0;
            pc_d = '0;
            ctrl_d = '0;
            reg_write_d = 1'b0;
            mem_read_d = 1'b0;
        end else if (ex_stall) begin
            // Held operands must still observe write-backs that land while we wait.
            if (wb_reg_write_enable && wb_reg_write_addr != 5'd0 && wb_reg_write_addr == rs_q)
                rs_data_d = wb_reg_write_data;
            if (wb_reg_write_enable && wb_reg_write_addr != 5'd0 && wb_reg_write_addr == rt_q)
                rt_data_d = wb_reg_write_data;
        end else if (hazard) begin
            valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d = 1'b0;
        end else begin
            valid_d = id_valid;
            rs_data_d = rs_res;
            rt_data_d = rt_res;
            rs_d = id_rs;
            rt_d = id_rt;
            dest_d = id_dest;
            imm_d = id_imm;
            pc_d = id_pc;
            ctrl_d = id_ctrl;
            reg_write_d = id_reg_write & id_valid;
            mem_read_d = id_mem_read & id_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            rs_q <= '0;
            rt_q <= '0;
            dest_q <= '0;
            imm_q <= '0;
            pc_q <= '0;
            ctrl_q <= '0;
            reg_write_q <= 1'b0;
            mem_read_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rs_q <= rs_d;
            rt_q <= rt_d;
            dest_q <= dest_d;
            imm_q <= imm_d;
            pc_q <= pc_d;
            ctrl_q <= ctrl_d;
            reg_write_q <= reg_write_d;
            mem_read_q <= mem_read_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_rs = rs_q;
    assign ex_rt = rt_q;
    assign ex_dest = dest_q;
    assign ex_imm = imm_q;
    assign ex_pc = pc_q;
    assign ex_ctrl = ctrl_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read = mem_read_q;
endmodule

// File: doc/id_ex_register.md
# id_ex_register

Decode-to-execute pipeline register for the MIPS-32 core. It sits directly downstream of the register file. It captures the two combinational read operands together with the decoded instruction fields, and bypasses same-cycle write-back data around the register file, because the file's read-during-write returns the old value. It also detects load-use hazards, inserts bubbles, and honours execute-side stall and flush.

## Interface
Parameters:
- CTRL_W, 12, width of opaque execute-stage control bundle (ALU op, src select, branch bits)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs, id_rt  in  5 each  source register numbers (also drive register file read_reg1/read_reg2)
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads that source
- id_dest  in  5  destination register number
- id_imm  in  32  sign/zero-extended immediate
- id_pc  in  32  PC+4 of the instruction
- id_ctrl  in  CTRL_W  execute control bundle
- id_reg_write, id_mem_read  in  1 each  instruction writes a register / is a load
- rf_read_data1, rf_read_data2  in  32 each  register file read data for id_rs / id_rt
- wb_reg_write_enable  in  1  write-back port enable (same net as register file write port)
- wb_reg_write_addr  in  5  write-back address
- wb_reg_write_data  in  32  write-back data
- ex_stall  in  1  execute cannot accept; hold contents
- flush  in  1  kill instruction in this stage (branch/jump redirect)
- id_stall  out  1  decode must hold its instruction this cycle
- ex_valid  out  1  stage holds a valid instruction
- ex_rs_data, ex_rt_data  out  32 each  resolved operands
- ex_rs, ex_rt, ex_dest  out  5 each  registered register numbers
- ex_imm, ex_pc  out  32 each  registered immediate / PC
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_reg_write, ex_mem_read  out  1 each  registered write/load flags, always 0 when ex_valid=0

## Operation
- Operand resolution, combinational, per source, highest priority first:
  - register number 0 -> 0x00000000
  - wb_reg_write_enable and wb_reg_write_addr equal to the source number -> wb_reg_write_data
  - otherwise the register file data
- Load-use hazard:
  - hazard = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & ((id_uses_rs & ex_dest==id_rs) | (id_uses_rt & ex_dest==id_rt))
- Stall output:
  - id_stall = ~flush & (ex_stall | hazard)
- Register update each rising edge, in priority order:
  1. flush:
     - ex_valid, ex_reg_write and ex_mem_read <= 0
     - other fields don't-care; implementation clears them to 0
  2. ex_stall (hold):
     - all fields retained
     - operand refresh: if wb_reg_write_enable, wb_reg_write_addr!=0 and wb_reg_write_addr==ex_rs, then ex_rs_data <= wb_reg_write_data
     - the same rule applies to ex_rt / ex_rt_data
     - prevents stale operands while held
  3. hazard (bubble):
     - ex_valid, ex_reg_write and ex_mem_read <= 0
     - decode holds, so the instruction re-presents next cycle
  4. load:
     - all fields <= decode inputs, with resolved operands
     - ex_valid <= id_valid
     - ex_reg_write <= id_reg_write & id_valid
     - ex_mem_read <= id_mem_read & id_valid
- No internal FSM beyond the valid bit. Bubble → reload is the only sequence.

## Timing
- Latency: 1 cycle, decode inputs to ex_* outputs.
- rst asserted: all ex_* outputs 0 immediately, independent of clk. id_stall then equals ex_stall (ex_valid=0, so hazard=0).
- rst deasserted: first load on the next rising edge.
- Load-use costs exactly one bubble cycle. On the following edge the load has left this stage, hazard drops, and the consumer loads. Its operand then comes from downstream forwarding, not from this block.
- flush with ex_stall in the same cycle: flush wins; id_stall=0.
- ex_stall with hazard: hold wins; no bubble is inserted; id_stall=1.
- WB write to register 0: never bypassed or refreshed.
- Both sources equal to the WB address: both operands take wb_reg_write_data.

## Test plan
- Reset mid-operation: load a valid instruction, then pulse rst between edges -> ex_valid, ex_rs_data and all ex_* read 0 before the next edge.
- Write-back bypass: register file returns 0x11111111 for r5. Same cycle: wb enable, addr 5, data 0xDEADBEEF, id_rs=id_rt=5 -> next edge ex_rs_data = ex_rt_data = 0xDEADBEEF.
- $zero: id_rs=0, rf data 0xFFFFFFFF, wb writes addr 0 with 0x1234 -> ex_rs_data=0.
- Load-use: ex stage holds lw with dest r8; decode holds add using r8 as rt -> id_stall=1; next edge ex_valid=0, ex_reg_write=0; following edge the add loads with ex_valid=1.
- Stall refresh: hold with ex_stall=1, ex_rt=9; wb writes r9=0xCAFEF00D -> ex_rt_data becomes 0xCAFEF00D, all other fields unchanged.
- Flush priority: flush=1, ex_stall=1, hazard conditions true -> id_stall=0; next edge ex_valid=0, ex_mem_read=0.
